// File: rtl/piso_tx_sched_pkg.sv
// Shared constants for the PISO transmit scheduler: default word width,
// FSM state encodings and the round-robin ready helper.
// Imported by piso_tx_sched and piso_tx_sched_core; no ports.
package piso_tx_sched_pkg;

    // Default serial word width.
    localparam int PISO_W_DEFAULT = 4;

    // FSM state encodings.
    localparam logic ST_IDLE_ENC  = 1'b0;
    localparam logic ST_SHIFT_ENC = 1'b1;

    typedef enum logic {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SHIFT = ST_SHIFT_ENC
    } state_e;

    // Ready for one requester of a two-way round-robin arbiter. It depends
    // only on the slot, on whether this side is favoured and on the other
    // side's valid, so a requester's ready never depends on its own valid.
    function automatic logic rr_ready(input logic slot,
                                      input logic favoured,
                                      input logic other_vld);
        return slot && (favoured || !other_vld);
    endfunction

endpackage

// File: rtl/piso_tx_sched_core.sv
// PISO shift-register core: W-bit register, parallel load or shift left
// (MSB out first), enable for freezing, synchronous clear.
// Ports: clk, reset_n, i_en, i_clr, i_pl, i_sdi, i_d[W-1:0] -> o_sdo (MSB).
module piso_tx_sched_core
    import piso_tx_sched_pkg::*;
#(
    parameter int W = PISO_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic         i_pl,
    input  logic         i_sdi,
    input  logic [W-1:0] i_d,
    output logic         o_sdo
);

    logic [W-1:0] r_shreg;

    // Clear wins over everything so an idle line always drives 0.
    // With the enable low the register (and therefore o_sdo) is frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg <= '0;
        end else if (i_clr) begin
            r_shreg <= '0;
        end else if (i_en) begin
            if (i_pl) begin
                r_shreg <= i_d;
            end else begin
                r_shreg <= {r_shreg[W-2:0], i_sdi};
            end
        end
    end

    assign o_sdo = r_shreg[W-1];

endmodule

// File: rtl/piso_tx_sched.sv
// Two-requester round-robin scheduler feeding a PISO core; words go out
// MSB-first one bit per clock with sdo_valid / frame_start / grant_id.
// Latency: transfer at edge N puts the MSB on o_sdo in cycle N+1.
// Backpressure: readies open only in IDLE or on the last bit with hold low,
// so streaming words are contiguous; i_hold freezes bits and closes readies.
// Ports: clk, reset_n, i_req{0,1}_valid/_data, o_req{0,1}_ready, i_hold,
//        o_sdo, o_sdo_valid, o_frame_start, o_grant_id, o_busy.
module piso_tx_sched
    import piso_tx_sched_pkg::*;
#(
    parameter int W = PISO_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_req0_valid,
    input  logic [W-1:0] i_req0_data,
    output logic         o_req0_ready,
    input  logic         i_req1_valid,
    input  logic [W-1:0] i_req1_data,
    output logic         o_req1_ready,
    input  logic         i_hold,
    output logic         o_sdo,
    output logic         o_sdo_valid,
    output logic         o_frame_start,
    output logic         o_grant_id,
    output logic         o_busy
);

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_prio;        // 0: requester 0 favoured
    logic          r_grant_id;
    logic          r_frame_start;

    logic          w_shifting;
    logic          w_last_bit;
    logic          w_advance;
    logic          w_slot;
    logic          w_rdy0;
    logic          w_rdy1;
    logic          w_xfer0;
    logic          w_xfer1;
    logic          w_xfer;
    logic          w_winner;
    logic [W-1:0]  w_load_dat;
    logic          w_core_en;
    logic          w_core_clr;

    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last_bit = w_shifting && (r_cnt == '0);
    // A bit leaves the line at the next edge only when shifting unheld.
    assign w_advance  = w_shifting && !i_hold;

    // Accept slot: idle, or the final bit is leaving this cycle. Taking the
    // next word here is what makes back-to-back frames gap-free.
    assign w_slot = (r_state == ST_IDLE) || (w_last_bit && !i_hold);

    assign w_rdy0 = rr_ready(w_slot, !r_prio, i_req1_valid);
    assign w_rdy1 = rr_ready(w_slot,  r_prio, i_req0_valid);

    // The ready terms are mutually exclusive whenever both sides are valid,
    // so at most one of these can be set.
    assign w_xfer0    = i_req0_valid && w_rdy0;
    assign w_xfer1    = i_req1_valid && w_rdy1;
    assign w_xfer     = w_xfer0 || w_xfer1;
    assign w_winner   = w_xfer1;
    assign w_load_dat = w_xfer1 ? i_req1_data : i_req0_data;

    // Load on transfer, shift while advancing, and wipe the register when
    // the final bit leaves with nothing behind it so idle sdo reads 0.
    assign w_core_en  = w_xfer || w_advance;
    assign w_core_clr = w_last_bit && !i_hold && !w_xfer;

    piso_tx_sched_core #(
        .W (W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_core_en),
        .i_clr   (w_core_clr),
        .i_pl    (w_xfer),
        .i_sdi   (1'b0),
        .i_d     (w_load_dat),
        .o_sdo   (o_sdo)
    );

    // Scheduler FSM. A transfer always (re)starts a frame, whether from
    // IDLE or on the last bit of the previous word. With hold high in SHIFT
    // nothing here changes, which keeps frame_start up on a held first bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_prio        <= 1'b0;
            r_grant_id    <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_xfer) begin
            r_state       <= ST_SHIFT;
            r_cnt         <= CNT_LAST;
            r_grant_id    <= w_winner;
            r_prio        <= ~w_winner;
            r_frame_start <= 1'b1;
        end else if (w_advance) begin
            r_frame_start <= 1'b0;
            if (r_cnt == '0) begin
                r_state <= ST_IDLE;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    assign o_req0_ready  = w_rdy0;
    assign o_req1_ready  = w_rdy1;
    assign o_sdo_valid   = w_shifting;
    assign o_busy        = w_shifting;
    assign o_frame_start = r_frame_start;
    assign o_grant_id    = r_grant_id;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Self-checking bench for piso_tx_sched (W=4): table-driven arbitration and
// streaming vectors plus hand-written hold and reset sequences; every
// serial bit is checked against a scoreboard queue filled at handshake time.
module tb_piso_tx_sched;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data = '0;
    logic         req1_ready;
    logic         hold = 1'b0;
    logic         sdo;
    logic         sdo_valid;
    logic         frame_start;
    logic         grant_id;
    logic         busy;

    piso_tx_sched #(.W(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_req0_valid  (req0_valid),
        .i_req0_data   (req0_data),
        .o_req0_ready  (req0_ready),
        .i_req1_valid  (req1_valid),
        .i_req1_data   (req1_data),
        .o_req1_ready  (req1_ready),
        .i_hold        (hold),
        .o_sdo         (sdo),
        .o_sdo_valid   (sdo_valid),
        .o_frame_start (frame_start),
        .o_grant_id    (grant_id),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic b;
        logic gnt;
        logic fs;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic         v0;
        logic         v1;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         g;      // expected winner
        int           delta;  // expected cycles since previous transfer, 0 = skip
        int           vexp;   // nonzero: group ends, expected sdo_valid cycles
        logic         rst;    // pulse reset before this vector
    } vec_t;
    vec_t tbl[10];

    int n_cmp  = 0;
    int n_fail = 0;
    int vcnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event not seen within budget (cycle %0d)", name, cyc);
    endtask

    // Per-cycle output check against the scoreboard head; a held bit is
    // compared again next cycle, so it is only popped when hold is low.
    task automatic mon();
        sb_t e;
        if (reset_n) begin
            if (sdo_valid) begin
                vcnt++;
                if (sbq.size() == 0) begin
                    fail_now("sb_underflow");
                end else begin
                    e = sbq[0];
                    chk("sdo", sdo, e.b);
                    chk("grant_id", grant_id, e.gnt);
                    chk("frame_start", frame_start, e.fs);
                    chk("busy_shift", busy, 1'b1);
                    if (!hold) void'(sbq.pop_front());
                end
            end else begin
                chk("idle_sdo", sdo, 1'b0);
                chk("idle_fs", frame_start, 1'b0);
                chk("idle_busy", busy, 1'b0);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        mon();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic g);
        for (int k = 0; k < W; k++) begin
            sbq.push_back('{b: d[W-1-k], gnt: g, fs: (k == 0)});
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 40; k++) begin
            sample();
            if (!sdo_valid && sbq.size() == 0) begin
                done = 1;
                break;
            end
            step();
        end
        if (!done) fail_now("drain");
        step();
    endtask

    // Wait for requester sel to be accepted (checked at the negedge before
    // the transfer edge).
    task automatic wait_hs(input logic sel, output bit ok);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            sample();
            if (sel ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) fail_now("handshake");
    endtask

    task automatic do_reset();
        req0_valid = 0;
        req1_valid = 0;
        reset_n    = 0;
        sbq.delete();
        step();
        step();
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit hs;
        logic g_act;
        int last_x;
        int vbase;

        // g1 single word; g2 back-to-back; g3 contention from reset;
        // g4 lone req1 then both valid with alternating priority.
        tbl[0] = '{1, 0, 4'b1011, 4'h0, 0, 0, 4,  0};
        tbl[1] = '{1, 0, 4'hA,    4'h0, 0, 0, 0,  0};
        tbl[2] = '{1, 0, 4'h5,    4'h0, 0, 4, 8,  0};
        tbl[3] = '{1, 1, 4'hF,    4'h0, 0, 0, 0,  1};
        tbl[4] = '{1, 1, 4'hF,    4'h0, 1, 4, 0,  0};
        tbl[5] = '{1, 1, 4'hF,    4'h0, 0, 4, 0,  0};
        tbl[6] = '{1, 1, 4'hF,    4'h0, 1, 4, 16, 0};
        tbl[7] = '{0, 1, 4'h0,    4'h3, 1, 0, 4,  0};
        tbl[8] = '{1, 1, 4'h6,    4'h9, 0, 0, 4,  0};
        tbl[9] = '{1, 1, 4'h6,    4'h9, 1, 0, 4,  0};

        // Reset state
        step();
        step();
        chk("rst_sdo", sdo, 0);
        chk("rst_sdo_valid", sdo_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_rdy0_novld", req0_ready, 1);
        chk("rst_rdy1_novld", req1_ready, 1);
        req0_valid = 1;
        req1_valid = 1;
        #1;
        chk("rst_rdy0_both", req0_ready, 1);
        chk("rst_rdy1_both", req1_ready, 0);
        step();
        chk("rst_no_xfer", sdo_valid, 0);
        req0_valid = 0;
        req1_valid = 0;
        reset_n = 1;
        step();

        vbase  = vcnt;
        last_x = 0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].rst) do_reset();
            if (i == 0 || tbl[i-1].vexp != 0) vbase = vcnt;
            req0_valid = tbl[i].v0;
            req1_valid = tbl[i].v1;
            req0_data  = tbl[i].d0;
            req1_data  = tbl[i].d1;
            hs = 0;
            for (int k = 0; k < 30; k++) begin
                sample();
                if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                    hs = 1;
                    break;
                end
                step();
            end
            if (!hs) begin
                fail_now("vec_handshake");
            end else begin
                g_act = req1_valid && req1_ready;
                chk("vec_grant", g_act, tbl[i].g);
                if (tbl[i].v0 && tbl[i].v1)
                    chk("vec_loser_ready", tbl[i].g ? req0_ready : req1_ready, 0);
                if (tbl[i].delta != 0)
                    chk("vec_xfer_spacing", cyc - last_x, tbl[i].delta);
                last_x = cyc;
                push_word(tbl[i].g ? tbl[i].d1 : tbl[i].d0, tbl[i].g);
                step();
            end
            if (tbl[i].vexp != 0) begin
                req0_valid = 0;
                req1_valid = 0;
                wait_idle();
                chk("vec_valid_cycles", vcnt - vbase, tbl[i].vexp);
            end
        end

        // Hold for 2 cycles on bit 2 of 4'b1001
        vbase = vcnt;
        req0_valid = 1;
        req0_data  = 4'b1001;
        wait_hs(0, ok);
        if (ok) push_word(4'b1001, 0);
        step();
        req0_valid = 0;
        sample(); step();            // bit 0
        sample(); step();            // bit 1
        hold = 1;                    // bit 2, first cycle
        req0_valid = 1;
        req1_valid = 1;
        sample();
        chk("hold_rdy0_a", req0_ready, 0);
        chk("hold_rdy1_a", req1_ready, 0);
        step();
        sample();
        chk("hold_rdy0_b", req0_ready, 0);
        chk("hold_rdy1_b", req1_ready, 0);
        step();
        hold = 0;
        req0_valid = 0;
        req1_valid = 0;
        wait_idle();
        chk("hold_valid_cycles", vcnt - vbase, 6);

        // Hold on the first bit (frame_start stays), then on the last bit
        // with a pending requester: closed while held, contiguous after.
        vbase = vcnt;
        req1_valid = 1;
        req1_data  = 4'b0110;
        wait_hs(1, ok);
        if (ok) push_word(4'b0110, 1);
        step();
        req1_valid = 0;
        hold = 1;
        sample(); step();            // bit 0 held
        hold = 0;
        sample(); step();            // bit 0
        sample(); step();            // bit 1
        sample(); step();            // bit 2
        hold = 1;                    // bit 3 held
        req0_valid = 1;
        req0_data  = 4'b1100;
        sample();
        chk("hold_last_rdy0", req0_ready, 0);
        step();
        hold = 0;
        sample();
        chk("last_bit_rdy0", req0_ready, 1);
        if (req0_ready) push_word(4'b1100, 0);
        step();
        req0_valid = 0;
        wait_idle();
        chk("hold2_valid_cycles", vcnt - vbase, 10);

        // Reset in bit 1 of a req1 word
        req1_valid = 1;
        req1_data  = 4'b0111;
        wait_hs(1, ok);
        if (ok) push_word(4'b0111, 1);
        step();
        req1_valid = 0;
        sample(); step();            // bit 0
        reset_n = 0;                 // during bit 1
        req0_valid = 1;
        req1_valid = 1;
        req0_data  = 4'b1001;
        req1_data  = 4'b0010;
        #1;
        chk("midrst_sdo", sdo, 0);
        chk("midrst_sdo_valid", sdo_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_start", frame_start, 0);
        chk("midrst_grant_id", grant_id, 0);
        sbq.delete();
        step();
        step();
        reset_n = 1;
        vbase = vcnt;
        sample();
        chk("postrst_rdy0", req0_ready, 1);
        chk("postrst_rdy1", req1_ready, 0);
        if (req0_ready) push_word(4'b1001, 0);
        step();
        req0_valid = 0;
        req1_valid = 0;
        wait_idle();
        chk("postrst_valid_cycles", vcnt - vbase, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
